pixfeed: RTL and testbench

Pixel feeder that sits directly upstream of the HDMI timing/encoder stage in the pixel-clock domain. It buffers a producer's pixel stream (valid/ready, with start-of-frame marker) in a show-ahead FIFO and presents one pixel at a time to the video generator, advancing on its read strobe. It enforces frame alignment: it holds off until a frame boundary, detects underrun and misalignment, and flushes and re-hunts for start-of-frame on either error.

---
 rtl/pixfeed_if.sv | 12 +
 rtl/pixfeed.sv | 154 +++++++++++++++
 tb/tb_pixfeed.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pixfeed_if.sv
// rtl/pixfeed_if.sv - producer pixel stream (valid/ready, pixel, start-of-frame) into the feeder
interface pixfeed_if #(
    parameter int BPP = 24
);
    logic           i_valid;
    logic           o_ready;
    logic [BPP-1:0] i_pixel;
    logic           i_sof;

    modport master (output i_valid, output i_pixel, output i_sof, input o_ready);
    modport slave  (input i_valid, input i_pixel, input i_sof, output o_ready);
endinterface

// File: rtl/pixfeed.sv
// rtl/pixfeed.sv - frame-aligned show-ahead pixel FIFO feeding the HDMI timing/encoder stage
// Optional underrun statistics counter enabled by defining PIXFEED_STATS_EN.
module pixfeed #(
    parameter int             LGFIFO = 10,
    parameter int             BPP    = 24,
    parameter logic [BPP-1:0] FILL   = 24'h000000
) (
    input  logic              i_pixclk,
    input  logic              i_reset_n,
    pixfeed_if.slave          s_pix,
    input  logic              i_rd,
    input  logic              i_newframe,
    output logic [BPP-1:0]    o_rgb_pix,
    output logic              o_synced,
    output logic              o_underflow,
    output logic              o_resync,
    output logic [LGFIFO:0]   o_fill,
    output logic [15:0]       o_underruns
);
    typedef enum logic [1:0] {HUNT, ARMED, RUN} state_t;

    localparam logic [LGFIFO:0] DEPTH = {1'b1, {LGFIFO{1'b0}}};

    state_t state, state_nxt;
    logic   first_pend, first_pend_nxt;
    logic   out_of_reset;

    logic [BPP:0]    mem [0:(1<<LGFIFO)-1];
    logic [LGFIFO:0] wr_ptr, rd_ptr, fill;
    logic [BPP:0]    pre_q, head_q;
    logic            pre_valid, head_valid;

    logic push, pop, underrun, misalign, err;
    logic mem_empty, pre_load, head_load;

    assign mem_empty     = (wr_ptr == rd_ptr);
    // Memory -> prefetch -> head gives the two-cycle fill latency while still popping one per clock.
    assign head_load     = pre_valid && (!head_valid || pop);
    assign pre_load      = !mem_empty && (!pre_valid || head_load);

    assign s_pix.o_ready = out_of_reset && ((state == HUNT) || (fill != DEPTH));
    assign o_rgb_pix     = head_valid ? head_q[BPP-1:0] : FILL;
    assign o_synced      = (state == RUN);
    assign o_fill        = fill;

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= HUNT;
            first_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            first_pend <= first_pend_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        first_pend_nxt = first_pend;
        underrun       = 1'b0;
        misalign       = 1'b0;
        pop            = 1'b0;
        case (state)
            HUNT: begin
                if (s_pix.i_valid && s_pix.o_ready && s_pix.i_sof)
                    state_nxt = ARMED;
            end
            ARMED: begin
                if (i_newframe) begin
                    state_nxt      = RUN;
                    first_pend_nxt = 1'b1;
                end
            end
            RUN: begin
                if (i_rd) begin
                    if (!head_valid) begin
                        underrun = 1'b1;
                    end else begin
                        pop            = 1'b1;
                        misalign       = (head_q[BPP] != first_pend);
                        first_pend_nxt = 1'b0;
                    end
                end
                if (i_newframe)
                    first_pend_nxt = 1'b1;
            end
            default: state_nxt = HUNT;
        endcase
        err = underrun || misalign;
        if (err) begin
            state_nxt      = HUNT;
            first_pend_nxt = 1'b0;
        end
        push = s_pix.i_valid && s_pix.o_ready && ((state != HUNT) || s_pix.i_sof) && !err;
    end

    always_ff @(posedge i_pixclk) begin
        if (push)
            mem[wr_ptr[LGFIFO-1:0]] <= {s_pix.i_sof, s_pix.i_pixel};
        if (pre_load)
            pre_q <= mem[rd_ptr[LGFIFO-1:0]];
        if (head_load)
            head_q <= pre_q;
    end

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            out_of_reset <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill         <= '0;
            pre_valid    <= 1'b0;
            head_valid   <= 1'b0;
            o_underflow  <= 1'b0;
            o_resync     <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
            o_underflow  <= underrun;
            o_resync     <= misalign;
            if (err) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fill       <= '0;
                pre_valid  <= 1'b0;
                head_valid <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pre_load)
                    rd_ptr <= rd_ptr + 1'b1;
                pre_valid  <= pre_load || (pre_valid && !head_load);
                head_valid <= head_load || (head_valid && !pop);
                if (push && !pop)
                    fill <= fill + 1'b1;
                else if (pop && !push)
                    fill <= fill - 1'b1;
            end
        end
    end

`ifdef PIXFEED_STATS_EN
    logic [15:0] underruns;

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n)
            underruns <= '0;
        else if (underrun && (underruns != 16'hFFFF))
            underruns <= underruns + 16'd1;
    end

    assign o_underruns = underruns;
`else
    assign o_underruns = 16'h0000;
`endif
endmodule

// File: tb/tb_pixfeed.sv
// tb/tb_pixfeed.sv - directed self-checking bench for pixfeed
module tb_pixfeed;
    localparam int LGFIFO = 10;
    localparam int BPP    = 24;
    localparam logic [BPP-1:0] FILL = 24'h000000;
`ifdef PIXFEED_STATS_EN
    localparam logic [15:0] EXP_UR = 16'd1;
`else
    localparam logic [15:0] EXP_UR = 16'd0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_rd = 1'b0;
    logic              i_newframe = 1'b0;
    logic [BPP-1:0]    o_rgb_pix;
    logic              o_synced, o_underflow, o_resync;
    logic [LGFIFO:0]   o_fill;
    logic [15:0]       o_underruns;
    int                checks = 0;
    int                errors = 0;

    pixfeed_if #(.BPP(BPP)) pif ();

    pixfeed #(.LGFIFO(LGFIFO), .BPP(BPP), .FILL(FILL)) dut (
        .i_pixclk    (clk),
        .i_reset_n   (rst_n),
        .s_pix       (pif.slave),
        .i_rd        (i_rd),
        .i_newframe  (i_newframe),
        .o_rgb_pix   (o_rgb_pix),
        .o_synced    (o_synced),
        .o_underflow (o_underflow),
        .o_resync    (o_resync),
        .o_fill      (o_fill),
        .o_underruns (o_underruns)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pix(input logic sof, input logic [BPP-1:0] pix);
        pif.i_valid = 1'b1;
        pif.i_sof   = sof;
        pif.i_pixel = pix;
        cyc();
        pif.i_valid = 1'b0;
        pif.i_sof   = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (pif.o_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", pif.o_ready); end
        checks++; if (o_rgb_pix !== FILL) begin errors++; $display("FAIL rst_pix got %h exp %h", o_rgb_pix, FILL); end
        checks++; if (o_synced !== 1'b0 || o_underflow !== 1'b0 || o_resync !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b%b exp 000", o_synced, o_underflow, o_resync); end
        checks++; if (o_fill !== 11'd0 || o_underruns !== 16'd0) begin errors++; $display("FAIL rst_counts got %0d/%0d exp 0/0", o_fill, o_underruns); end
        cyc(); cyc();
        rst_n = 1'b1;
        checks++; if (pif.o_ready !== 1'b0) begin errors++; $display("FAIL rel_ready_early got %b exp 0", pif.o_ready); end
        cyc();
        checks++; if (pif.o_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got %b exp 1", pif.o_ready); end
    endtask

    task automatic test_hunt_discard();
        for (int i = 0; i < 4; i++) push_pix(1'b0, 24'hA00000 + 24'(i));
        cyc(); cyc();
        checks++; if (o_fill !== 11'd0) begin errors++; $display("FAIL hunt_fill got %0d exp 0", o_fill); end
        checks++; if (o_rgb_pix !== FILL) begin errors++; $display("FAIL hunt_pix got %h exp %h", o_rgb_pix, FILL); end
        checks++; if (o_synced !== 1'b0) begin errors++; $display("FAIL hunt_synced got %b exp 0", o_synced); end
    endtask

    task automatic test_basic_frame();
        push_pix(1'b1, 24'h112233);
        checks++; if (o_rgb_pix !== FILL) begin errors++; $display("FAIL lat1 got %h exp %h", o_rgb_pix, FILL); end
        push_pix(1'b0, 24'h445566);
        checks++; if (o_rgb_pix !== FILL) begin errors++; $display("FAIL lat2 got %h exp %h", o_rgb_pix, FILL); end
        cyc();
        checks++; if (o_rgb_pix !== 24'h112233) begin errors++; $display("FAIL lat_head got %h exp 112233", o_rgb_pix); end
        checks++; if (o_fill !== 11'd2) begin errors++; $display("FAIL basic_fill got %0d exp 2", o_fill); end
        i_newframe = 1'b1; cyc(); i_newframe = 1'b0;
        checks++; if (o_synced !== 1'b1) begin errors++; $display("FAIL basic_synced got %b exp 1", o_synced); end
        i_rd = 1'b1;
        cyc();
        checks++; if (o_rgb_pix !== 24'h445566) begin errors++; $display("FAIL basic_pop1 got %h exp 445566", o_rgb_pix); end
        cyc();
        i_rd = 1'b0;
        checks++; if (o_rgb_pix !== FILL || o_fill !== 11'd0) begin errors++; $display("FAIL basic_drain got %h/%0d exp %h/0", o_rgb_pix, o_fill, FILL); end
        checks++; if (o_underflow !== 1'b0 || o_resync !== 1'b0 || o_synced !== 1'b1) begin errors++; $display("FAIL basic_flags got uf=%b rs=%b sy=%b exp 0 0 1", o_underflow, o_resync, o_synced); end
    endtask

    task automatic test_underrun();
        push_pix(1'b0, 24'hAABBCC);
        cyc(); cyc();
        checks++; if (o_rgb_pix !== 24'hAABBCC || o_fill !== 11'd1) begin errors++; $display("FAIL ur_pre got %h/%0d exp aabbcc/1", o_rgb_pix, o_fill); end
        i_rd = 1'b1;
        cyc();
        checks++; if (o_rgb_pix !== FILL || o_underflow !== 1'b0 || o_synced !== 1'b1) begin errors++; $display("FAIL ur_pop got %h uf=%b sy=%b exp %h 0 1", o_rgb_pix, o_underflow, o_synced, FILL); end
        cyc();
        i_rd = 1'b0;
        checks++; if (o_underflow !== 1'b1 || o_synced !== 1'b0) begin errors++; $display("FAIL ur_pulse got uf=%b sy=%b exp 1 0", o_underflow, o_synced); end
        checks++; if (o_fill !== 11'd0 || o_underruns !== EXP_UR) begin errors++; $display("FAIL ur_counts got %0d/%0d exp 0/%0d", o_fill, o_underruns, EXP_UR); end
        cyc();
        checks++; if (o_underflow !== 1'b0 || pif.o_ready !== 1'b1) begin errors++; $display("FAIL ur_after got uf=%b rdy=%b exp 0 1", o_underflow, pif.o_ready); end
    endtask

    task automatic test_resync();
        push_pix(1'b1, 24'h010203);
        push_pix(1'b0, 24'h040506);
        cyc(); cyc();
        i_newframe = 1'b1; i_rd = 1'b1;
        cyc();
        i_newframe = 1'b0;
        checks++; if (o_synced !== 1'b1 || o_rgb_pix !== 24'h010203 || o_fill !== 11'd2 || o_underflow !== 1'b0) begin errors++; $display("FAIL nf_rd_same got sy=%b %h %0d uf=%b exp 1 010203 2 0", o_synced, o_rgb_pix, o_fill, o_underflow); end
        cyc();
        i_rd = 1'b0;
        checks++; if (o_rgb_pix !== 24'h040506 || o_resync !== 1'b0) begin errors++; $display("FAIL rs_sofpop got %h rs=%b exp 040506 0", o_rgb_pix, o_resync); end
        i_newframe = 1'b1; cyc(); i_newframe = 1'b0;
        i_rd = 1'b1; cyc(); i_rd = 1'b0;
        checks++; if (o_resync !== 1'b1 || o_synced !== 1'b0) begin errors++; $display("FAIL rs_pulse got rs=%b sy=%b exp 1 0", o_resync, o_synced); end
        checks++; if (o_fill !== 11'd0 || o_rgb_pix !== FILL || o_underruns !== EXP_UR) begin errors++; $display("FAIL rs_flush got %0d %h %0d exp 0 %h %0d", o_fill, o_rgb_pix, o_underruns, FILL, EXP_UR); end
        push_pix(1'b0, 24'h777777);
        checks++; if (o_resync !== 1'b0 || o_fill !== 11'd0) begin errors++; $display("FAIL rs_hunt got rs=%b %0d exp 0 0", o_resync, o_fill); end
        push_pix(1'b1, 24'h0A0B0C);
        cyc(); cyc();
        checks++; if (o_fill !== 11'd1 || o_rgb_pix !== 24'h0A0B0C || o_synced !== 1'b0) begin errors++; $display("FAIL rs_rearm got %0d %h sy=%b exp 1 0a0b0c 0", o_fill, o_rgb_pix, o_synced); end
    endtask

    task automatic test_full();
        pif.i_valid = 1'b1;
        pif.i_sof   = 1'b0;
        for (int i = 0; i < 1023; i++) begin
            pif.i_pixel = 24'h100000 + 24'(i);
            cyc();
        end
        pif.i_pixel = 24'hEEEEEE;
        cyc(); cyc();
        checks++; if (o_fill !== 11'd1024 || pif.o_ready !== 1'b0) begin errors++; $display("FAIL full_level got %0d rdy=%b exp 1024 0", o_fill, pif.o_ready); end
        i_newframe = 1'b1; cyc(); i_newframe = 1'b0;
        i_rd = 1'b1; cyc(); i_rd = 1'b0;
        checks++; if (o_fill !== 11'd1023 || pif.o_ready !== 1'b1 || o_resync !== 1'b0) begin errors++; $display("FAIL full_pop got %0d rdy=%b rs=%b exp 1023 1 0", o_fill, pif.o_ready, o_resync); end
        checks++; if (o_rgb_pix !== 24'h100000) begin errors++; $display("FAIL full_order got %h exp 100000", o_rgb_pix); end
        cyc();
        pif.i_valid = 1'b0;
        checks++; if (o_fill !== 11'd1024 || pif.o_ready !== 1'b0) begin errors++; $display("FAIL full_refill got %0d rdy=%b exp 1024 0", o_fill, pif.o_ready); end
        i_rd = 1'b1; cyc(); i_rd = 1'b0;
        checks++; if (o_rgb_pix !== 24'h100001 || o_fill !== 11'd1023) begin errors++; $display("FAIL full_noovw got %h/%0d exp 100001/1023", o_rgb_pix, o_fill); end
    endtask

    task automatic test_async_reset();
        rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();
        push_pix(1'b1, 24'h200000);
        for (int i = 1; i < 37; i++) push_pix(1'b0, 24'h200000 + 24'(i));
        cyc(); cyc();
        i_newframe = 1'b1; cyc(); i_newframe = 1'b0;
        checks++; if (o_fill !== 11'd37 || o_synced !== 1'b1 || o_rgb_pix !== 24'h200000) begin errors++; $display("FAIL ar_pre got %0d sy=%b %h exp 37 1 200000", o_fill, o_synced, o_rgb_pix); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (o_fill !== 11'd0 || o_synced !== 1'b0 || pif.o_ready !== 1'b0 || o_rgb_pix !== FILL) begin errors++; $display("FAIL ar_async got %0d sy=%b rdy=%b %h exp 0 0 0 %h", o_fill, o_synced, pif.o_ready, o_rgb_pix, FILL); end
        checks++; if (o_underflow !== 1'b0 || o_resync !== 1'b0 || o_underruns !== 16'd0) begin errors++; $display("FAIL ar_flags got uf=%b rs=%b ur=%0d exp 0 0 0", o_underflow, o_resync, o_underruns); end
        cyc();
        rst_n = 1'b1;
        cyc();
        push_pix(1'b0, 24'h333333);
        cyc(); cyc();
        checks++; if (o_fill !== 11'd0 || o_synced !== 1'b0 || pif.o_ready !== 1'b1 || o_rgb_pix !== FILL) begin errors++; $display("FAIL ar_hunt got %0d sy=%b rdy=%b %h exp 0 0 1 %h", o_fill, o_synced, pif.o_ready, o_rgb_pix, FILL); end
    endtask

    initial begin
        pif.i_valid = 1'b0;
        pif.i_sof   = 1'b0;
        pif.i_pixel = '0;
        test_reset();
        test_hunt_discard();
        test_basic_frame();
        test_underrun();
        test_resync();
        test_full();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
